// File: rtl/system_client1_cpu_mult_combine.sv
// Combines the lo*lo, lo*hi and hi*lo partial products into the low 32 bits of a 32x32
// product through a 2-stage pipeline and a small output FIFO. Optional MULT_COMBINE_STATS_EN adds ops_count.
module system_client1_cpu_mult_combine #(
    parameter int TAG_W   = 5,
    parameter int FIFO_AW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef MULT_COMBINE_STATS_EN
    ,
    output logic [31:0]      ops_count
`endif
);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic               v1_reg;
    logic [31:0]        r1_p1_reg;
    logic [15:0]        r1_s16_reg;
    logic [TAG_W-1:0]   r1_tag_reg;
    logic               v2_reg;
    logic [31:0]        r2_res_reg;
    logic [TAG_W-1:0]   r2_tag_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [FIFO_AW:0]   count_next;
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [31:0]        mem_res [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];

    logic adv;
    logic accept;
    logic push;
    logic pop;

    // Upper halves of the cross terms only affect bits above 31.
    logic unused_hi;
    assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign adv       = ~v2_reg | (count_reg < (FIFO_AW + 1)'(DEPTH)) | pop;
    assign in_ready  = adv & ~flush & ~reset;
    assign accept    = in_valid & in_ready;
    assign push      = v2_reg & adv;
    assign busy      = v1_reg | v2_reg | out_valid;

    assign out_result = mem_res[rd_ptr_reg];
    assign out_tag    = mem_tag[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else if (adv) begin
            v1_reg <= accept;
            v2_reg <= v1_reg;
        end
    end

    // Data registers only move with the pipe; stale contents are harmless behind the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_p1_reg  <= '0;
            r1_s16_reg <= '0;
            r1_tag_reg <= '0;
            r2_res_reg <= '0;
            r2_tag_reg <= '0;
        end else if (adv) begin
            if (accept) begin
                r1_p1_reg  <= in_p1;
                r1_s16_reg <= in_p2[15:0] + in_p3[15:0];
                r1_tag_reg <= in_tag;
            end
            r2_res_reg <= r1_p1_reg + {r1_s16_reg, 16'h0000};
            r2_tag_reg <= r1_tag_reg;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_res[gi] <= '0;
                    mem_tag[gi] <= '0;
                end else if (push && !flush && wr_ptr_reg == FIFO_AW'(gi)) begin
                    mem_res[gi] <= r2_res_reg;
                    mem_tag[gi] <= r2_tag_reg;
                end
            end
        end
    endgenerate

`ifdef MULT_COMBINE_STATS_EN
    logic [31:0] ops_count_reg;
    always_ff @(posedge clk) begin
        if (reset)    ops_count_reg <= '0;
        else if (pop) ops_count_reg <= ops_count_reg + 32'd1;
    end
    assign ops_count = ops_count_reg;
`endif
endmodule

// File: tb/tb_system_client1_cpu_mult_combine.sv
// Randomised + directed self-checking bench for system_client1_cpu_mult_combine, using a
// queue-based transaction model of the pipe; the MULT_COMBINE_STATS_EN build also checks ops_count.
module tb_system_client1_cpu_mult_combine;
    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_p1 = '0, in_p2 = '0, in_p3 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
`ifdef MULT_COMBINE_STATS_EN
    logic [31:0]      ops_count;
`endif

    system_client1_cpu_mult_combine #(.TAG_W(TAG_W), .FIFO_AW(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
`ifdef MULT_COMBINE_STATS_EN
        , .ops_count(ops_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each op becomes its final product at acceptance.
    typedef struct { logic [31:0] res; logic [TAG_W-1:0] tag; } op_t;
    op_t         mq[$];
    op_t         m_s1, m_s2;
    bit          m_v1 = 0, m_v2 = 0, m_ok = 0;
    longint      m_ops = 0;
    logic [TAG_W-1:0] popped[$];

    function automatic logic [31:0] product(input logic [31:0] p1, p2, p3);
        longint s;
        s = longint'(p1) + ((longint'(p2) + longint'(p3)) << 16);
        return s[31:0];
    endfunction

    always @(posedge clk) begin
        bit pop, adv, acc;
        pop = (mq.size() != 0) && out_ready;
        adv = !m_v2 || (mq.size() < DEPTH) || pop;
        acc = in_valid && adv && !flush && !reset;
        if (!reset && pop) m_ops++;
        if (reset || flush) begin
            mq.delete();
            m_v1 = 0;
            m_v2 = 0;
            if (reset) begin m_ops = 0; m_ok = 1; end
        end else begin
            if (pop) void'(mq.pop_front());
            if (adv) begin
                if (m_v2) mq.push_back(m_s2);
                m_v2 = m_v1;
                m_s2 = m_s1;
                m_v1 = acc;
                if (acc) m_s1 = '{res: product(in_p1, in_p2, in_p3), tag: in_tag};
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            bit exp_rdy;
            exp_rdy = (!m_v2 || mq.size() < DEPTH || (mq.size() != 0 && out_ready)) && !flush && !reset;
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_v1 || m_v2 || mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_result", out_result, mq[0].res);
                chk("out_tag", 32'(out_tag), 32'(mq[0].tag));
            end
`ifdef MULT_COMBINE_STATS_EN
            chk("ops_count", ops_count, m_ops[31:0]);
`endif
            if (out_valid && out_ready) popped.push_back(out_tag);
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] p1, p2, p3, input logic [TAG_W-1:0] tag);
        bit got = 0;
        in_valid = 1'b1; in_p1 = p1; in_p2 = p2; in_p3 = p3; in_tag = tag;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string name, input logic [31:0] res, input logic [TAG_W-1:0] tag);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                chk({name, "_res"}, out_result, res);
                chk({name, "_tag"}, 32'(out_tag), 32'(tag));
            end
            step();
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        int t;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        step();

        // Basic op with latency pinned: accept at edge N, visible after edge N+2.
        out_ready = 1'b1;
        in_valid = 1'b1; in_p1 = 32'h0000000F; in_p2 = 32'h6; in_p3 = 32'h5; in_tag = 5'd3;
        @(negedge clk); chk("basic_accept", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("lat_n", 32'(out_valid), 32'd0);
        step();
        @(negedge clk); chk("lat_n1", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("lat_n2", 32'(out_valid), 32'd1);
        chk("basic_res", out_result, 32'h000B000F);
        chk("basic_tag", 32'(out_tag), 32'd3);
        step();

        send(32'hFFFFFFFF, 32'h0000FFFF, 32'h00000001, 5'd4);
        expect_out("wrap1", 32'hFFFFFFFF, 5'd4);
        send(32'hFFFF0000, 32'h1, 32'h0, 5'd5);
        expect_out("wrap2", 32'h00000000, 5'd5);
        repeat (4) step();

        // Backpressure: only four ops fit (S1, S2, two FIFO entries).
        out_ready = 1'b0;
        popped.delete();
        t = 1;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            in_valid = (t <= 6); in_tag = 5'(t);
            in_p1 = 32'(t) * 32'h01010101; in_p2 = 32'(t); in_p3 = 32'hFFFF;
            @(negedge clk); acc = in_valid && in_ready;
            step();
            if (acc) t++;
        end
        chk("bp_accepts", 32'(t - 1), 32'd4);
        // Full FIFO with v2 set: a pop frees the slot in the same edge.
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bit acc;
            in_valid = (t <= 6); in_tag = 5'(t);
            in_p1 = 32'(t) * 32'h01010101; in_p2 = 32'(t); in_p3 = 32'hFFFF;
            @(negedge clk);
            if (c == 0) chk("full_simul_in_ready", 32'(in_ready), 32'd1);
            acc = in_valid && in_ready;
            step();
            if (acc) t++;
        end
        in_valid = 1'b0;
        chk("bp_drain_count", 32'(popped.size()), 32'd6);
        for (int i = 0; i < 6 && i < popped.size(); i++)
            chk("bp_order", 32'(popped[i]), 32'(i + 1));

        // Flush with three ops in flight.
        out_ready = 1'b0;
        send(32'h1, 32'h1, 32'h1, 5'd10);
        send(32'h2, 32'h2, 32'h2, 5'd11);
        send(32'h3, 32'h3, 32'h3, 5'd12);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        step();
        out_ready = 1'b1;
        send(32'h12345678, 32'h00010002, 32'h00000003, 5'd9);
        expect_out("post_flush", 32'h12395678, 5'd9);
        repeat (4) step();

        // Random traffic including occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            in_p1 = $urandom(); in_p2 = $urandom(); in_p3 = $urandom();
            in_tag = 5'($urandom());
            step();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (6) step();

`ifdef MULT_COMBINE_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) send(32'(i), 32'(i), 32'(i), 5'(i));
        repeat (6) step();
        @(negedge clk); chk("stats_five", ops_count, 32'd5);
        step();
        flush = 1'b1; step(); flush = 1'b0;
        @(negedge clk); chk("stats_flush_keeps", ops_count, 32'd5);
        step();
        do_reset();
        @(negedge clk); chk("stats_reset", ops_count, 32'd0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
